// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the picoMIPS core: one clk domain, one-cycle cpu_en,
// prescaled free-run, debounced single-step and sticky halt, with an enable counter.
module cpu_run_ctrl #(
  parameter int unsigned DIV        = 5000000,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic             clr_halt,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] en_count
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t        st;
  logic [PW-1:0] pre;
  logic          sync1, sync2;
  logic          deb_lvl;
  logic [DW-1:0] deb_cnt;
  logic          step_pulse;

  // Step button: 2-FF synchronizer, level debounce, rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      deb_lvl    <= 1'b0;
      deb_cnt    <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync1      <= step_btn;
      sync2      <= sync1;
      step_pulse <= 1'b0;
      if (sync2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        deb_lvl    <= sync2;
        deb_cnt    <= '0;
        step_pulse <= sync2;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Prescaler is only non-zero while staying in RUN, so every entry starts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      pre <= '0;
    end else begin
      case (st)
        IDLE: begin
          pre <= '0;
          if (run)             st <= RUN;
          else if (step_pulse) st <= STEP;
        end
        RUN: begin
          if (halt_req) begin
            st  <= HALTED;
            pre <= '0;
          end else if (!run) begin
            st  <= IDLE;
            pre <= '0;
          end else begin
            pre <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
          end
        end
        STEP: begin
          pre <= '0;
          if (halt_req) st <= HALTED;
          else if (run) st <= RUN;
          else          st <= IDLE;
        end
        HALTED: begin
          pre <= '0;
          if (clr_halt) st <= IDLE;
        end
        default: begin
          st  <= IDLE;
          pre <= '0;
        end
      endcase
    end
  end

  always_comb begin
    cpu_en = ((st == RUN) && (pre == PRE_MAX)) || (st == STEP);
    state  = st;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_count <= '0;
    end else if (cpu_en && (en_count != '1)) begin
      en_count <= en_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step controller for the picoMIPS core on the DE0 board.
- Replaces the free-running slow-clock divider with a single `clk` domain and a one-cycle clock-enable (`cpu_en`) to the cpu.
- Supports free-run at a prescaled rate, debounced single-step from a push button, and a sticky halt requested by the core.
- Counts delivered enables for LED/debug display.

Parameters:
- DIV, 5000000, prescaler period in clk cycles between enables in RUN (≥1; 10 Hz at 50 MHz)
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a step-button level change (≥1)
- CNT_W, 16, width of enable counter

Ports:
- clk  in  1  system clock (DE0 50 MHz)
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level, synchronous: 1 = free-run requested
- step_btn  in  1  raw asynchronous push button, active-high
- halt_req  in  1  synchronous from cpu: halt instruction retired
- clr_halt  in  1  synchronous level: release HALTED
- cpu_en  out  1  one-cycle clock enable to cpu
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALTED
- en_count  out  CNT_W  number of cpu_en cycles delivered, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE; prescaler=0; sync FFs, debounced level, debounce counter, step pulse=0; en_count=0; cpu_en=0. All logic is in the `clk` domain.
- Step input path:
  - 2-FF synchronizer on step_btn.
  - Debounce counter counts while the synced value differs from the debounced level; it clears when they are equal.
  - When the count reaches DEB_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - step_pulse is registered, high for exactly 1 cycle on a 0→1 change of the debounced level. No pulse on release.
- cpu_en = (state==RUN && pre==DIV-1) || state==STEP. It is decoded from registers only.
- Prescaler:
  - Cleared on every entry to RUN. Increments each RUN cycle; wraps to 0 after DIV-1.
  - Held at 0 outside RUN.
  - First enable occurs DIV cycles after the first RUN cycle. DIV=1 gives cpu_en every RUN cycle.
- Transitions, evaluated each cycle, priority in listed order:
  - IDLE: run=1 → RUN; else step_pulse → STEP; else stay.
  - RUN: halt_req → HALTED; else run=0 → IDLE; else stay.
  - STEP: always one cycle. halt_req → HALTED; else run=1 → RUN; else → IDLE.
  - HALTED: clr_halt=1 → IDLE; else stay. run, step_pulse and halt_req are ignored.
- An enable already decoded in the same cycle as halt_req or run=0 is still delivered; the next cycle has cpu_en=0.
- A step_pulse arriving in RUN, STEP or HALTED is discarded, not queued.
- Holding step_btn produces exactly one step. A new step requires release to be debounced, then a new press.
- en_count increments on every cycle with cpu_en=1 and saturates at 2^CNT_W-1. Only rst_n clears it; clr_halt does not.
- state output equals the state register. There is no additional latency.
- Reset asserted mid-RUN or mid-debounce aborts immediately; cpu_en=0 while rst_n=0.

Test Plan (DIV=4, DEB_CYCLES=3, CNT_W=4):
- Free-run: after reset, run=1 for 20 cycles → state=01 from cycle 1; cpu_en high on RUN cycles 4, 8, 12, 16, 20; en_count=5.
- Single step: run=0, step_btn held high 10 cycles → exactly one cpu_en pulse, 2 sync + 3 debounce + 1 pulse cycles after the press, then state 10 → 00; en_count=1. A 2-cycle glitch on step_btn produces no step.
- Halt: in RUN, assert halt_req 1 cycle coincident with a cpu_en → that enable counts, state=11 next cycle, no further cpu_en despite run=1 and button presses. clr_halt=1 with run=1 → IDLE, then RUN with prescaler restarted at 0.
- Run drop: run goes 1→0 at prescaler=2 → IDLE next cycle, no enable. run back to 1 → first enable DIV cycles later, not 1.
- Saturation: run=1, DIV=1 for 20 cycles → en_count stops at 15; cpu_en continues every cycle.
- Async reset mid-RUN between clock edges → state=00, cpu_en=0, en_count=0 immediately. After release, behaviour matches a fresh reset.
